// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter (package instruction_set).
package instruction_set;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MEM_OPS_T;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } ARB_STATE_T;

  localparam int unsigned DATA_MEM_SIZE = 32'd4096;

  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned size);
    return {16'd0, addr} < size;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select: fixed core priority, or round-robin when RR_ARB_EN is defined.
module arb_pick (
  input  logic i_core_req,
  input  logic i_ext_req,
`ifdef RR_ARB_EN
  input  logic i_last_ext,
`endif
  output logic o_pick_ext
);

`ifdef RR_ARB_EN
  // On a tie the requester that did not win last time goes next.
  assign o_pick_ext = (i_core_req && i_ext_req) ? ~i_last_ext : (i_ext_req & ~i_core_req);
`else
  assign o_pick_ext = i_ext_req & ~i_core_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter (core vs external loader).
// Define RR_ARB_EN for round-robin arbitration; default is fixed core priority.
module mem_arbiter
  import instruction_set::*;
#(
  parameter int unsigned DATA_MEM_SIZE = instruction_set::DATA_MEM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  MEM_OPS_T    core_op,
  input  logic [15:0] core_addr,
  input  logic [15:0] core_wdata,
  input  logic        ext_req,
  input  MEM_OPS_T    ext_op,
  input  logic [15:0] ext_addr,
  input  logic [15:0] ext_wdata,
  output logic        core_gnt,
  output logic        ext_gnt,
  output logic        core_rvalid,
  output logic [15:0] core_rdata,
  output logic        ext_rvalid,
  output logic [15:0] ext_rdata,
  output MEM_OPS_T    mem_op,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        addr_err
);

  ARB_STATE_T  r_state;
  MEM_OPS_T    r_op;
  MEM_OPS_T    r_mem_op;
  logic        r_win_ext;
  logic        r_err;
  logic        r_core_gnt;
  logic        r_ext_gnt;
  logic        r_addr_err;
  logic        r_rvalid;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
`ifdef RR_ARB_EN
  logic        r_last_ext;
`endif

  logic        w_pick_ext;
  MEM_OPS_T    w_op;
  logic [15:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_err;

  arb_pick u_arb_pick (
    .i_core_req (core_req),
    .i_ext_req  (ext_req),
`ifdef RR_ARB_EN
    .i_last_ext (r_last_ext),
`endif
    .o_pick_ext (w_pick_ext)
  );

  assign w_op    = w_pick_ext ? ext_op    : core_op;
  assign w_addr  = w_pick_ext ? ext_addr  : core_addr;
  assign w_wdata = w_pick_ext ? ext_wdata : core_wdata;
  assign w_err   = ~addr_in_range(w_addr, DATA_MEM_SIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= MEM_NOP;
      r_mem_op    <= MEM_NOP;
      r_win_ext   <= 1'b0;
      r_err       <= 1'b0;
      r_core_gnt  <= 1'b0;
      r_ext_gnt   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
`ifdef RR_ARB_EN
      r_last_ext  <= 1'b1;
`endif
    end else begin
      // Pulses and memory strobes default low; only the IDLE->ISSUE edge raises them.
      r_core_gnt  <= 1'b0;
      r_ext_gnt   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_mem_op    <= MEM_NOP;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      case (r_state)
        IDLE: begin
          if (core_req || ext_req) begin
            r_state    <= ISSUE;
            r_win_ext  <= w_pick_ext;
            r_op       <= w_op;
            r_err      <= w_err;
            r_core_gnt <= ~w_pick_ext;
            r_ext_gnt  <= w_pick_ext;
            r_addr_err <= w_err;
`ifdef RR_ARB_EN
            r_last_ext <= w_pick_ext;
`endif
            if (!w_err) begin
              r_mem_op    <= w_op;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ISSUE: begin
          if (r_op == MEM_READ) begin
            r_state  <= RDWAIT;
            r_rvalid <= 1'b1;
          end else begin
            r_state  <= IDLE;
          end
        end
        RDWAIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_gnt  = r_core_gnt;
  assign ext_gnt   = r_ext_gnt;
  assign addr_err  = r_addr_err;
  assign mem_op    = r_mem_op;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Memory data arrives in RDWAIT, so rdata is steered live; reset kills an in-flight response.
  assign core_rvalid = r_rvalid & ~r_win_ext & ~reset;
  assign ext_rvalid  = r_rvalid &  r_win_ext & ~reset;
  assign core_rdata  = (core_rvalid && !r_err) ? mem_rdata : 16'h0000;
  assign ext_rdata   = (ext_rvalid  && !r_err) ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/reads, a negedge monitor checks them.
module tb_mem_arbiter;
  import instruction_set::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, ext_req;
  MEM_OPS_T    core_op, ext_op;
  logic [15:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic        core_gnt, ext_gnt, core_rvalid, ext_rvalid, addr_err;
  logic [15:0] core_rdata, ext_rdata;
  MEM_OPS_T    mem_op;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  typedef struct {
    logic        ext;
    MEM_OPS_T    op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    int          cyc;
  } gnt_exp_t;

  typedef struct {
    logic        ext;
    logic [15:0] rdata;
    int          cyc;
  } rd_exp_t;

  gnt_exp_t gq[$];
  rd_exp_t  rq[$];
  gnt_exp_t ge;
  rd_exp_t  re;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] mem [0:DATA_MEM_SIZE-1];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
    .ext_req(ext_req), .ext_op(ext_op), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .core_gnt(core_gnt), .ext_gnt(ext_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory with one-cycle read latency; rdata holds its last value otherwise.
  always @(posedge clk) begin
    if (mem_op == MEM_WRITE) mem[mem_addr] <= mem_wdata;
    if (mem_op == MEM_READ)  mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents a grant or read response.
  always @(negedge clk) begin
    if (core_gnt || ext_gnt) begin
      chk("single_gnt", {31'd0, core_gnt & ext_gnt}, 32'd0);
      if (gq.size() == 0) begin
        chk("unexpected_gnt", {30'd0, core_gnt, ext_gnt}, 32'd0);
      end else begin
        ge = gq.pop_front();
        chk("gnt_who", {31'd0, ext_gnt}, {31'd0, ge.ext});
        chk("gnt_cycle", cyc, ge.cyc);
        chk("mem_op", {30'd0, mem_op}, {30'd0, (ge.err ? MEM_NOP : ge.op)});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, (ge.err ? 16'h0000 : ge.addr)});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, (ge.err ? 16'h0000 : ge.wdata)});
        chk("addr_err", {31'd0, addr_err}, {31'd0, ge.err});
      end
    end else begin
      chk("idle_op_err", {29'd0, addr_err, mem_op}, 32'd0);
      chk("idle_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    end
    if (core_rvalid || ext_rvalid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, core_rvalid, ext_rvalid}, 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rvalid_who", {30'd0, core_rvalid, ext_rvalid}, {30'd0, ~re.ext, re.ext});
        chk("rvalid_cycle", cyc, re.cyc);
        chk("rdata", {16'd0, (re.ext ? ext_rdata : core_rdata)}, {16'd0, re.rdata});
        chk("other_rdata", {16'd0, (re.ext ? core_rdata : ext_rdata)}, 32'd0);
      end
    end else begin
      chk("idle_rdata", {core_rdata, ext_rdata}, 32'd0);
    end
  end

  task automatic check_reset_values();
    chk("rst_gnt_rvalid_err", {27'd0, core_gnt, ext_gnt, core_rvalid, ext_rvalid, addr_err}, 32'd0);
    chk("rst_mem_op", {30'd0, mem_op}, {30'd0, MEM_NOP});
    chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_rdata", {core_rdata, ext_rdata}, 32'd0);
  endtask

  task automatic drive(input logic ext, input MEM_OPS_T op, input logic [15:0] addr,
                       input logic [15:0] wdata);
    if (ext) begin
      ext_req = 1'b1; ext_op = op; ext_addr = addr; ext_wdata = wdata;
    end else begin
      core_req = 1'b1; core_op = op; core_addr = addr; core_wdata = wdata;
    end
  endtask

  // Issue one request from IDLE, wait for its grant, and return once the arbiter is idle again.
  task automatic do_req(input logic ext, input MEM_OPS_T op, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rexp);
    logic err;
    logic seen;
    err  = ({16'd0, addr} >= DATA_MEM_SIZE);
    seen = 1'b0;
    drive(ext, op, addr, wdata);
    gq.push_back('{ext, op, addr, wdata, err, cyc + 1});
    if (op == MEM_READ) rq.push_back('{ext, (err ? 16'h0000 : rexp), cyc + 2});
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ext ? ext_gnt : core_gnt;
    end
    if (ext) ext_req = 1'b0; else core_req = 1'b0;
    @(posedge clk); #1;
    if (op == MEM_READ) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DATA_MEM_SIZE; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    core_req = 1'b0; core_op = MEM_NOP; core_addr = 16'h0000; core_wdata = 16'h0000;
    ext_req  = 1'b0; ext_op  = MEM_NOP; ext_addr  = 16'h0000; ext_wdata  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: core write 0x0010 <- 0xBEEF
    do_req(1'b0, MEM_WRITE, 16'h0010, 16'hBEEF, 16'h0000);

    // A request raised only while the arbiter is busy and dropped before IDLE is ignored.
    drive(1'b0, MEM_WRITE, 16'h0011, 16'h1111);
    gq.push_back('{1'b0, MEM_WRITE, 16'h0011, 16'h1111, 1'b0, cyc + 1});
    @(posedge clk); #1;
    core_req = 1'b0;
    drive(1'b1, MEM_WRITE, 16'h0099, 16'hDEAD);
    @(posedge clk); #1;
    ext_req = 1'b0;
    @(posedge clk); #1;

    // Scenario 2: ext read 0x0010 returns 0xBEEF
    do_req(1'b1, MEM_READ, 16'h0010, 16'h0000, 16'hBEEF);

    // Scenario 3: both requesters held for four grants
    drive(1'b0, MEM_WRITE, 16'h0020, 16'hC001);
    drive(1'b1, MEM_WRITE, 16'h0021, 16'hE001);
    for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_EN
      if (k % 2 == 0) gq.push_back('{1'b0, MEM_WRITE, 16'h0020, 16'hC001, 1'b0, cyc + 1 + 2 * k});
      else            gq.push_back('{1'b1, MEM_WRITE, 16'h0021, 16'hE001, 1'b0, cyc + 1 + 2 * k});
`else
      gq.push_back('{1'b0, MEM_WRITE, 16'h0020, 16'hC001, 1'b0, cyc + 1 + 2 * k});
`endif
    end
    repeat (7) @(posedge clk);
    #1;
    core_req = 1'b0;
    ext_req  = 1'b0;
    @(posedge clk); #1;

    // Top valid address, then scenario 4: read exactly at DATA_MEM_SIZE
    do_req(1'b1, MEM_WRITE, 16'(DATA_MEM_SIZE - 1), 16'h5A5A, 16'h0000);
    do_req(1'b1, MEM_READ,  16'(DATA_MEM_SIZE - 1), 16'h0000, 16'h5A5A);
    do_req(1'b0, MEM_READ,  16'(DATA_MEM_SIZE), 16'h0000, 16'h0000);
    do_req(1'b1, MEM_WRITE, 16'hFFFF, 16'h7777, 16'h0000);

    // Scenario 5: reset lands in RDWAIT; no response, then normal service
    drive(1'b1, MEM_READ, 16'h0010, 16'h0000);
    gq.push_back('{1'b1, MEM_READ, 16'h0010, 16'h0000, 1'b0, cyc + 1});
    @(posedge clk); #1;
    ext_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, MEM_WRITE, 16'h0030, 16'h1234, 16'h0000);
    do_req(1'b0, MEM_READ,  16'h0030, 16'h0000, 16'h1234);

    repeat (4) @(posedge clk);
    #1;
    chk("gnt_queue_drained", gq.size(), 32'd0);
    chk("rd_queue_drained", rq.size(), 32'd0);
    chk("ignored_req_no_write", {16'd0, mem[16'h0099]}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
